// File: rtl/wave_capture.sv
// wave_capture: arms on a positive zero crossing, captures 2**ADDR_W offset-binary samples into the
// RAM half the display is not reading, then waits for display idle to swap halves and re-arm.
module wave_capture #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready,
    input  logic [15:0]       new_sample_in,
    input  logic              wave_display_idle,
    output logic [ADDR_W:0]   write_address,
    output logic              write_enable,
    output logic [7:0]        write_sample,
    output logic              read_index
);
    localparam logic [1:0] ARMED = 2'd0, ACTIVE = 2'd1, WAIT = 2'd2;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [15:0]       prev_q, prev_d;
    logic              ri_q, ri_d, we_q, we_d, crossing, wr;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    always_comb begin
        crossing = new_sample_ready & prev_q[15] & ~new_sample_in[15];
        wr       = (state_q == ARMED) ? crossing : (state_q == ACTIVE) & new_sample_ready;
        prev_d   = new_sample_ready ? new_sample_in : prev_q;
        we_d     = wr;
        // count is 0 whenever ARMED (reset or wrap), so the crossing sample lands at index 0
        addr_d   = wr ? {~ri_q, count_q} : addr_q;
        data_d   = wr ? {~new_sample_in[15], new_sample_in[14:8]} : data_q;
        count_d  = wr ? count_q + 1'b1 : count_q;
        ri_d     = ri_q ^ ((state_q == WAIT) & wave_display_idle);
        state_d  = (state_q == ARMED && crossing)          ? ACTIVE :
                   (state_q == ACTIVE && wr && &count_q)   ? WAIT   :
                   (state_q == WAIT && wave_display_idle)  ? ARMED  :
                   (state_q == 2'd3)                       ? ARMED  : state_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARMED;
            count_q <= '0;
            prev_q  <= '0;
            ri_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            ri_q    <= ri_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = data_q;
    assign read_index    = ri_q;
endmodule
